// File: rtl/multi_pc_if.sv
// Fetch-offer and next-PC-update bundle between the multi-context PC unit and the pipeline.
// master = PC unit side, slave = fetch/execute side.
interface multi_pc_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 2
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [CW-1:0]    fetch_ctx;
  logic [WIDTH-1:0] fetch_pc;
  logic             upd_valid;
  logic [CW-1:0]    upd_ctx;
  logic [1:0]       PCMUX;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] offset;
  logic             upd_err;

  modport master (
    output fetch_valid, fetch_ctx, fetch_pc, upd_err,
    input  fetch_ready, upd_valid, upd_ctx, PCMUX, bus, offset
  );

  modport slave (
    input  fetch_valid, fetch_ctx, fetch_pc, upd_err,
    output fetch_ready, upd_valid, upd_ctx, PCMUX, bus, offset
  );
endinterface

// File: rtl/multi_pc.sv
// Multi-context program counter: NUM_CTX barrel-style PCs with a round-robin fetch scheduler.
// Optional per-context fetch counters are enabled with `define MULTI_PC_PERF_EN.
module multi_pc #(
  parameter int               WIDTH    = 16,
  parameter int               NUM_CTX  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int              CW       = $clog2(NUM_CTX)
) (
  input  logic               Clk,
  input  logic               Reset_ah,
  input  logic [NUM_CTX-1:0] ctx_en,
`ifdef MULTI_PC_PERF_EN
  input  logic [CW-1:0]      perf_sel,
  output logic [15:0]        perf_cnt,
`endif
  multi_pc_if.master         pif
);

  localparam logic [CW:0] NUM_CTX_W = (CW+1)'(NUM_CTX);
  localparam bit          CTX_POW2  = (NUM_CTX == (1 << CW));

  typedef enum logic {
    CTX_READY = 1'b0,
    CTX_WAIT  = 1'b1
  } ctx_state_t;

  ctx_state_t       state_q [NUM_CTX];
  ctx_state_t       state_d [NUM_CTX];
  logic [WIDTH-1:0] pc_q    [NUM_CTX];
  logic [CW-1:0]    rr_ptr_q;
  logic [CW-1:0]    rr_ptr_d;
  logic [CW-1:0]    scan_idx;
  logic [CW-1:0]    sel_ctx;
  logic             sel_found;
  logic             fetch_fire;
  logic             upd_in_range;
  logic             upd_ok;
  logic             upd_err_q;

  // (base + step) mod NUM_CTX for base < NUM_CTX and step < NUM_CTX
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int step);
    logic [CW:0] s;
    s = {1'b0, base} + (CW+1)'(step);
    if (s >= NUM_CTX_W) s = s - NUM_CTX_W;
    return s[CW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] next_pc(input logic [WIDTH-1:0] pc,
                                               input logic [1:0]       sel,
                                               input logic [WIDTH-1:0] bus_val,
                                               input logic [WIDTH-1:0] off_val);
    case (sel)
      2'b00:   return pc + WIDTH'(1);
      2'b01:   return bus_val;
      2'b10:   return off_val;
      default: return pc;
    endcase
  endfunction

  generate
    if (CTX_POW2) begin : g_rng_pow2
      assign upd_in_range = 1'b1;
    end else begin : g_rng_cmp
      assign upd_in_range = ({1'b0, pif.upd_ctx} < NUM_CTX_W);
    end
  endgenerate

  // Round-robin scan starting at rr_ptr; falls back to rr_ptr when nothing is offered
  always_comb begin
    sel_found = 1'b0;
    sel_ctx   = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int k = 0; k < NUM_CTX; k++) begin
      scan_idx = wrap_add(rr_ptr_q, k);
      if (!sel_found && state_q[scan_idx] == CTX_READY && ctx_en[scan_idx]) begin
        sel_found = 1'b1;
        sel_ctx   = scan_idx;
      end
    end
  end

  assign fetch_fire = sel_found & pif.fetch_ready;
  assign upd_ok     = pif.upd_valid & upd_in_range & (state_q[pif.upd_ctx] == CTX_WAIT);

  // Fetch only claims a READY context and update only releases a WAIT one, so both may apply
  always_comb begin
    for (int i = 0; i < NUM_CTX; i++) state_d[i] = state_q[i];
    rr_ptr_d = rr_ptr_q;
    if (fetch_fire) begin
      state_d[sel_ctx] = CTX_WAIT;
      rr_ptr_d         = wrap_add(sel_ctx, 1);
    end
    if (upd_ok) state_d[pif.upd_ctx] = CTX_READY;
  end

  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        state_q[i] <= CTX_READY;
        pc_q[i]    <= RESET_PC;
      end
      rr_ptr_q  <= '0;
      upd_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) state_q[i] <= state_d[i];
      rr_ptr_q  <= rr_ptr_d;
      upd_err_q <= pif.upd_valid & ~upd_ok;
      if (upd_ok) pc_q[pif.upd_ctx] <= next_pc(pc_q[pif.upd_ctx], pif.PCMUX, pif.bus, pif.offset);
    end
  end

  assign pif.fetch_valid = sel_found;
  assign pif.fetch_ctx   = sel_ctx;
  assign pif.fetch_pc    = pc_q[sel_ctx];
  assign pif.upd_err     = upd_err_q;

`ifdef MULTI_PC_PERF_EN
  logic [15:0] fetch_cnt_q [NUM_CTX];
  logic        perf_in_range;

  generate
    if (CTX_POW2) begin : g_perf_pow2
      assign perf_in_range = 1'b1;
    end else begin : g_perf_cmp
      assign perf_in_range = ({1'b0, perf_sel} < NUM_CTX_W);
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      for (int i = 0; i < NUM_CTX; i++) fetch_cnt_q[i] <= '0;
    end else if (fetch_fire && fetch_cnt_q[sel_ctx] != 16'hFFFF) begin
      fetch_cnt_q[sel_ctx] <= fetch_cnt_q[sel_ctx] + 16'd1;
    end
  end

  assign perf_cnt = perf_in_range ? fetch_cnt_q[perf_sel] : 16'h0000;
`endif

endmodule

// File: tb/tb_multi_pc.sv
// Directed bench for multi_pc: a per-cycle reference model plus hand-computed offer checks.
module tb_multi_pc;
  localparam int NCTX = 4;

  logic        Clk = 1'b0;
  logic        Reset_ah;
  logic [3:0]  ctx_en;
`ifdef MULTI_PC_PERF_EN
  logic [1:0]  perf_sel;
  logic [15:0] perf_cnt;
`endif

  multi_pc_if #(.WIDTH(16), .CW(2)) pif ();

  multi_pc #(.WIDTH(16), .NUM_CTX(NCTX), .RESET_PC(16'h0000)) dut (
    .Clk      (Clk),
    .Reset_ah (Reset_ah),
    .ctx_en   (ctx_en),
`ifdef MULTI_PC_PERF_EN
    .perf_sel (perf_sel),
    .perf_cnt (perf_cnt),
`endif
    .pif      (pif)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: what each context holds, per the scheduling rules
  logic [15:0] m_pc   [NCTX] = '{default: 16'h0000};
  bit          m_busy [NCTX] = '{default: 1'b0};
  int          m_ptr  = 0;
  bit          m_err  = 1'b0;
  logic [15:0] m_cnt  [NCTX] = '{default: 16'h0000};

  function automatic void m_offer(output bit v, output int c);
    v = 1'b0;
    c = m_ptr;
    for (int k = 0; k < NCTX; k++) begin
      int i;
      i = (m_ptr + k) % NCTX;
      if (!v && !m_busy[i] && ctx_en[i]) begin
        v = 1'b1;
        c = i;
      end
    end
  endfunction

  bit          mv;
  int          mc;
  bit          mok;
  int          muc;
  logic [15:0] mnew;

  always @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      for (int i = 0; i < NCTX; i++) begin
        m_pc[i]   <= 16'h0000;
        m_busy[i] <= 1'b0;
        m_cnt[i]  <= 16'h0000;
      end
      m_ptr <= 0;
      m_err <= 1'b0;
    end else begin
      m_offer(mv, mc);
      muc = int'(pif.upd_ctx);
      mok = pif.upd_valid && muc < NCTX && m_busy[muc];
      if (mok) begin
        case (pif.PCMUX)
          2'b00:   mnew = m_pc[muc] + 16'h0001;
          2'b01:   mnew = pif.bus;
          2'b10:   mnew = pif.offset;
          default: mnew = m_pc[muc];
        endcase
        m_pc[muc]   <= mnew;
        m_busy[muc] <= 1'b0;
      end
      if (mv && pif.fetch_ready) begin
        m_busy[mc] <= 1'b1;
        m_ptr      <= (mc + 1) % NCTX;
        if (m_cnt[mc] != 16'hFFFF) m_cnt[mc] <= m_cnt[mc] + 16'h0001;
      end
      m_err <= pif.upd_valid && !mok;
    end
  end

  bit cv;
  int cc;
  always @(negedge Clk) begin
    m_offer(cv, cc);
    check("mdl_valid", {31'd0, pif.fetch_valid}, {31'd0, cv});
    check("mdl_ctx",   {30'd0, pif.fetch_ctx},   cc);
    check("mdl_pc",    {16'd0, pif.fetch_pc},    {16'd0, m_pc[cc]});
    check("mdl_err",   {31'd0, pif.upd_err},     {31'd0, m_err});
`ifdef MULTI_PC_PERF_EN
    check("mdl_perf",  {16'd0, perf_cnt},        {16'd0, m_cnt[perf_sel]});
`endif
  end

  task automatic drive(input logic [3:0] en, input logic rdy, input logic uv,
                       input logic [1:0] uc, input logic [1:0] mux,
                       input logic [15:0] b, input logic [15:0] o);
    ctx_en          = en;
    pif.fetch_ready = rdy;
    pif.upd_valid   = uv;
    pif.upd_ctx     = uc;
    pif.PCMUX       = mux;
    pif.bus         = b;
    pif.offset      = o;
`ifdef MULTI_PC_PERF_EN
    perf_sel        = uc;
`endif
    #1;
  endtask

  task automatic idle(input logic [3:0] en, input logic rdy);
    drive(en, rdy, 1'b0, 2'd0, 2'b00, 16'h0000, 16'h0000);
  endtask

  task automatic upd(input logic [3:0] en, input logic rdy, input logic [1:0] uc,
                     input logic [1:0] mux, input logic [15:0] b, input logic [15:0] o);
    drive(en, rdy, 1'b1, uc, mux, b, o);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic offer(input string name, input logic v, input logic [1:0] c, input logic [15:0] pc);
    check({name, "_v"},  {31'd0, pif.fetch_valid}, {31'd0, v});
    check({name, "_c"},  {30'd0, pif.fetch_ctx},   {30'd0, c});
    check({name, "_pc"}, {16'd0, pif.fetch_pc},    {16'd0, pc});
  endtask

  initial begin
    Reset_ah = 1'b1;
    idle(4'b1111, 1'b0);
    offer("rst_all", 1'b1, 2'd0, 16'h0000);
    idle(4'b0110, 1'b0);
    offer("rst_lowen", 1'b1, 2'd1, 16'h0000);
    tick();
    Reset_ah = 1'b0;

    // All enabled: plain round robin, then nothing left to offer
    for (int i = 0; i < 4; i++) begin
      idle(4'b1111, 1'b1);
      offer("rr4", 1'b1, 2'(i), 16'h0000);
      tick();
    end
    idle(4'b1111, 1'b1);
    offer("rr4_empty", 1'b0, 2'd0, 16'h0000);

    // PCMUX encodings on context 1
    upd(4'b0010, 1'b0, 2'd1, 2'b01, 16'h0010, 16'h0000); tick();
    idle(4'b0010, 1'b1); offer("c1_load", 1'b1, 2'd1, 16'h0010); tick();
    upd(4'b0010, 1'b1, 2'd1, 2'b00, 16'h0000, 16'h0000);
    check("no_bypass", {31'd0, pif.fetch_valid}, 32'd0);
    tick();
    idle(4'b0010, 1'b1); offer("c1_inc", 1'b1, 2'd1, 16'h0011); tick();
    upd(4'b0010, 1'b1, 2'd1, 2'b01, 16'h1234, 16'h0000); tick();
    idle(4'b0010, 1'b1); offer("c1_bus", 1'b1, 2'd1, 16'h1234); tick();
    upd(4'b0010, 1'b1, 2'd1, 2'b10, 16'h0000, 16'h00AB); tick();
    idle(4'b0010, 1'b1); offer("c1_off", 1'b1, 2'd1, 16'h00AB); tick();
    upd(4'b0010, 1'b1, 2'd1, 2'b11, 16'h5555, 16'h7777); tick();
    idle(4'b0010, 1'b1); offer("c1_hold", 1'b1, 2'd1, 16'h00AB); tick();

    // PC+1 wraps FFFF -> 0000 on context 2
    upd(4'b0100, 1'b0, 2'd2, 2'b01, 16'hFFFF, 16'h0000); tick();
    idle(4'b0100, 1'b1); offer("c2_ffff", 1'b1, 2'd2, 16'hFFFF); tick();
    upd(4'b0100, 1'b0, 2'd2, 2'b00, 16'h0000, 16'h0000); tick();
    idle(4'b0100, 1'b0); offer("c2_wrap", 1'b1, 2'd2, 16'h0000); tick();

    // Update to a READY context is dropped and flagged one cycle later
    upd(4'b0001, 1'b0, 2'd0, 2'b01, 16'h0040, 16'h0000); tick();
    upd(4'b0001, 1'b0, 2'd0, 2'b01, 16'h9999, 16'h0000);
    check("err_pre", {31'd0, pif.upd_err}, 32'd0);
    tick();
    idle(4'b0001, 1'b0);
    check("err_pulse", {31'd0, pif.upd_err}, 32'd1);
    tick();
    check("err_clear", {31'd0, pif.upd_err}, 32'd0);
    offer("c0_kept", 1'b1, 2'd0, 16'h0040);

    // Fetch of ctx 3 and update of ctx 1 in the same cycle
    upd(4'b1000, 1'b0, 2'd3, 2'b00, 16'h0000, 16'h0000); tick();
    upd(4'b1000, 1'b1, 2'd1, 2'b00, 16'h0000, 16'h0000);
    offer("same_c3", 1'b1, 2'd3, 16'h0001);
    tick();
    idle(4'b0010, 1'b0); offer("same_c1", 1'b1, 2'd1, 16'h00AC);
    idle(4'b1000, 1'b0);
    check("same_c3_wait", {31'd0, pif.fetch_valid}, 32'd0);
    tick();

    // Partial enable: 0,2,0,2 with the previous fetch returned each cycle
    idle(4'b0101, 1'b1);                                 offer("en5_a", 1'b1, 2'd0, 16'h0040); tick();
    upd(4'b0101, 1'b1, 2'd0, 2'b00, 16'h0000, 16'h0000); offer("en5_b", 1'b1, 2'd2, 16'h0000); tick();
    upd(4'b0101, 1'b1, 2'd2, 2'b00, 16'h0000, 16'h0000); offer("en5_c", 1'b1, 2'd0, 16'h0041); tick();
    upd(4'b0101, 1'b1, 2'd0, 2'b00, 16'h0000, 16'h0000); offer("en5_d", 1'b1, 2'd2, 16'h0001); tick();

    // fetch_ready low: pointer and states hold
    upd(4'b0101, 1'b0, 2'd2, 2'b00, 16'h0000, 16'h0000); offer("stall_a", 1'b1, 2'd0, 16'h0042); tick();
    for (int i = 0; i < 3; i++) begin
      idle(4'b0101, 1'b0); offer("stall_h", 1'b1, 2'd0, 16'h0042); tick();
    end

    // Reset with contexts 0 and 3 waiting and an update in flight
    idle(4'b0001, 1'b1); offer("pre_rst", 1'b1, 2'd0, 16'h0042); tick();
    upd(4'b1111, 1'b0, 2'd0, 2'b01, 16'hBEEF, 16'h0000);
    Reset_ah = 1'b1;
    #1;
    offer("mid_rst", 1'b1, 2'd0, 16'h0000);
    tick();
    tick();
    Reset_ah = 1'b0;
    idle(4'b1111, 1'b0);
    check("rst_err", {31'd0, pif.upd_err}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(4'b1111, 1'b1);
      offer("post_rst", 1'b1, 2'(i), 16'h0000);
      tick();
    end
    idle(4'b1111, 1'b1);
    check("post_rst_empty", {31'd0, pif.fetch_valid}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
